fifo_flex: RTL and testbench

Single-clock synchronous FIFO. It is the parametrised successor of the team's basic FIFO.
- Adds correct simultaneous read/write and a selectable showahead or normal read mode.
- Adds a synchronous flush and sticky overflow/underflow error flags.
- Sits between producer and consumer stages inside one clock domain, as a drop-in buffer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ram.sv | 47 ++++
 rtl/fifo_flex.sv | 136 +++++++++++++
 tb/tb_fifo_flex.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and elaboration helpers for fifo_flex.
//   fifo_err_t     - sticky error flags {overflow, underflow}
//   fifo_depth()   - word count for a given address width (2**aw)
//   fifo_params_ok - parameter range check used at elaboration time
package fifo_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic bit fifo_params_ok(input int unsigned dw, input int unsigned aw,
                                        input int unsigned af, input int unsigned ae);
    return (dw >= 1) && (af <= fifo_depth(aw)) && (ae <= fifo_depth(aw));
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port memory, one write port and one read port.
//   clk_i            clock
//   srst_i           synchronous reset of the registered read data only
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read port (re_i used only when SYNC_READ != 0)
//   rdata_o          read data: registered when SYNC_READ != 0, else combinational
// Memory contents are never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned SYNC_READ = 0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = fifo_depth(AWIDTH);

  logic [DWIDTH-1:0] mem_q [Depth];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  // The unused path is a constant-selected mux leg and is pruned by synthesis.
  assign rdata_o = (SYNC_READ != 0) ? rdata_q : mem_q[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock synchronous FIFO with showahead/normal read mode,
// synchronous flush and sticky overflow/underflow flags.
//   clk_i, srst_i (sync, active-high), flush_i (sync, clears contents and errors)
//   data_i/wrreq_i write side; rdreq_i read request (ack in showahead mode); q_o read data
//   empty_o, full_o, usedw_o (0..2**AWIDTH), almost_full_o (usedw >= ALMOST_FULL_VALUE),
//   almost_empty_o (usedw < ALMOST_EMPTY_VALUE), overflow_o, underflow_o (sticky)
// Optional macro FIFO_PEAK_EN adds peak_usedw_o, a registered high-water mark of usedw_o.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH             = 16,
  parameter int unsigned AWIDTH             = 5,
  parameter int unsigned SHOWAHEAD          = 1,
  parameter int unsigned ALMOST_FULL_VALUE  = 29,
  parameter int unsigned ALMOST_EMPTY_VALUE = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
`ifdef FIFO_PEAK_EN
  ,
  output logic [AWIDTH:0]   peak_usedw_o
`endif
);

  localparam int unsigned Depth = fifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] DepthCnt = (AWIDTH+1)'(Depth);
  localparam logic [AWIDTH:0] AfThresh = (AWIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AeThresh = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);

  if (!fifo_params_ok(DWIDTH, AWIDTH, ALMOST_FULL_VALUE, ALMOST_EMPTY_VALUE)) begin : g_bad_params
    $error("fifo_flex: DWIDTH must be >= 1 and thresholds must not exceed 2**AWIDTH");
  end

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  fifo_err_t         err_q, err_d;
  logic              wr_acc, rd_acc;
  logic              ram_we, ram_re;
  logic [DWIDTH-1:0] ram_rdata;

  assign empty_o        = (usedw_q == '0);
  assign full_o         = (usedw_q == DepthCnt);
  assign almost_full_o  = (usedw_q >= AfThresh);
  assign almost_empty_o = (usedw_q < AeThresh);
  assign usedw_o        = usedw_q;
  assign overflow_o     = err_q.overflow;
  assign underflow_o    = err_q.underflow;

  assign wr_acc = wrreq_i && !full_o;
  assign rd_acc = rdreq_i && !empty_o;

  // Flush and reset suppress memory and read-register updates in their cycle.
  assign ram_we = wr_acc && !srst_i && !flush_i;
  assign ram_re = rd_acc && !srst_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    err_d    = err_q;
    if (srst_i || flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      err_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !rd_acc) begin
        usedw_d = usedw_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        usedw_d = usedw_q - 1'b1;
      end
      if (wrreq_i && full_o)  err_d.overflow  = 1'b1;
      if (rdreq_i && empty_o) err_d.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    usedw_q  <= usedw_d;
    err_q    <= err_d;
  end

  fifo_ram #(
    .DWIDTH    (DWIDTH),
    .AWIDTH    (AWIDTH),
    .SYNC_READ ((SHOWAHEAD != 0) ? 0 : 1)
  ) u_ram (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Showahead exposes the head word combinationally and forces zero while empty.
  assign q_o = (SHOWAHEAD != 0) ? (empty_o ? '0 : ram_rdata) : ram_rdata;

`ifdef FIFO_PEAK_EN
  logic [AWIDTH:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (srst_i || flush_i) begin
      peak_d = '0;
    end else if (usedw_q > peak_q) begin
      peak_d = usedw_q;
    end
  end

  always_ff @(posedge clk_i) begin
    peak_q <= peak_d;
  end

  assign peak_usedw_o = peak_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: drives identical directed stimulus into a showahead and a normal-mode
// fifo_flex and checks both against a queue-based model every cycle, plus literal checks.
module tb_fifo_flex;

  localparam int unsigned Depth = 32;

  logic        clk = 1'b0;
  logic        srst, flush, wrreq, rdreq;
  logic [15:0] din;

  logic [15:0] sa_q, nm_q;
  logic        sa_empty, sa_full, sa_af, sa_ae, sa_ovf, sa_unf;
  logic        nm_empty, nm_full, nm_af, nm_ae, nm_ovf, nm_unf;
  logic [5:0]  sa_usedw, nm_usedw;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state
  logic [15:0] mq[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [15:0] m_qnm = '0;

  always #5 clk = ~clk;

  fifo_flex #(.SHOWAHEAD(1)) dut_sa (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .data_i(din), .wrreq_i(wrreq),
    .rdreq_i(rdreq), .q_o(sa_q), .empty_o(sa_empty), .full_o(sa_full), .usedw_o(sa_usedw),
    .almost_full_o(sa_af), .almost_empty_o(sa_ae), .overflow_o(sa_ovf), .underflow_o(sa_unf)
  );

  fifo_flex #(.SHOWAHEAD(0)) dut_nm (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .data_i(din), .wrreq_i(wrreq),
    .rdreq_i(rdreq), .q_o(nm_q), .empty_o(nm_empty), .full_o(nm_full), .usedw_o(nm_usedw),
    .almost_full_o(nm_af), .almost_empty_o(nm_ae), .overflow_o(nm_ovf), .underflow_o(nm_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, applying the accept/priority rules at each rising edge.
  task automatic model_step();
    int sz;
    sz = mq.size();
    if (srst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_qnm = '0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wrreq && sz == Depth) m_ovf = 1'b1;
      if (rdreq && sz == 0)     m_unf = 1'b1;
      if (rdreq && sz > 0)      m_qnm = mq.pop_front();
      if (wrreq && sz < Depth)  mq.push_back(din);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      logic [15:0] head;
      sz   = mq.size();
      head = (sz > 0) ? mq[0] : 16'h0;
      chk("sa_usedw", 32'(sa_usedw), sz);
      chk("sa_empty", 32'(sa_empty), 32'(sz == 0));
      chk("sa_full",  32'(sa_full),  32'(sz == Depth));
      chk("sa_af",    32'(sa_af),    32'(sz >= 29));
      chk("sa_ae",    32'(sa_ae),    32'(sz < 3));
      chk("sa_ovf",   32'(sa_ovf),   32'(m_ovf));
      chk("sa_unf",   32'(sa_unf),   32'(m_unf));
      chk("sa_q",     32'(sa_q),     32'(head));
      chk("nm_usedw", 32'(nm_usedw), sz);
      chk("nm_empty", 32'(nm_empty), 32'(sz == 0));
      chk("nm_full",  32'(nm_full),  32'(sz == Depth));
      chk("nm_af",    32'(nm_af),    32'(sz >= 29));
      chk("nm_ae",    32'(nm_ae),    32'(sz < 3));
      chk("nm_ovf",   32'(nm_ovf),   32'(m_ovf));
      chk("nm_unf",   32'(nm_unf),   32'(m_unf));
      chk("nm_q",     32'(nm_q),     32'(m_qnm));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst = 1'b1; flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; din = '0;
    step();
    chk_en = 1'b1;
    step();
    srst = 1'b0;
    chk("rst_usedw", 32'(sa_usedw), 0);
    chk("rst_empty", 32'(sa_empty), 1);
    chk("rst_ae",    32'(sa_ae), 1);
    chk("rst_q_sa",  32'(sa_q), 0);
    chk("rst_q_nm",  32'(nm_q), 0);

    // 1: fill to full, almost_full from 29, overflow on the 33rd write, then drain
    wrreq = 1'b1;
    for (int i = 0; i < 32; i++) begin
      din = 16'(i);
      step();
      if (i == 27) chk("t1_af_28", 32'(sa_af), 0);
      if (i == 28) chk("t1_af_29", 32'(sa_af), 1);
    end
    chk("t1_full",  32'(sa_full), 1);
    chk("t1_usedw", 32'(sa_usedw), 32);
    din = 16'hDEAD;
    step();
    wrreq = 1'b0;
    chk("t1_ovf",      32'(sa_ovf), 1);
    chk("t1_usedw_ov", 32'(sa_usedw), 32);
    for (int i = 0; i < 32; i++) begin
      chk("t1_head", 32'(sa_q), i);
      rdreq = 1'b1;
      step();
      chk("t1_nm_q", 32'(nm_q), i);
    end
    rdreq = 1'b0;
    chk("t1_empty", 32'(sa_empty), 1);

    // 2: showahead single word
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t2_ovf_clr", 32'(sa_ovf), 0);
    wrreq = 1'b1; din = 16'hA5A5;
    step();
    wrreq = 1'b0;
    chk("t2_empty0", 32'(sa_empty), 0);
    chk("t2_q",      32'(sa_q), 32'hA5A5);
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk("t2_empty1", 32'(sa_empty), 1);
    chk("t2_q0",     32'(sa_q), 0);
    chk("t2_nm_q",   32'(nm_q), 32'hA5A5);

    // 3: steady state at 5 words, simultaneous read/write for 40 cycles
    wrreq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 16'(16'h0100 + k);
      step();
    end
    rdreq = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 16'(16'h0200 + k);
      step();
      chk("t3_usedw", 32'(sa_usedw), 5);
      chk("t3_order", 32'(nm_q), (k < 5) ? (32'h100 + k) : (32'h200 + k - 5));
    end
    wrreq = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rdreq = 1'b0;
    chk("t3_empty", 32'(sa_empty), 1);

    // 4: normal-mode reads and underflow
    wrreq = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      din = 16'(k);
      step();
    end
    wrreq = 1'b0;
    rdreq = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t4_nm_q", 32'(nm_q), k);
    end
    step();
    rdreq = 1'b0;
    chk("t4_unf",     32'(nm_unf), 1);
    chk("t4_q_hold",  32'(nm_q), 3);
    chk("t4_sa_unf",  32'(sa_unf), 1);

    // 5: flush with usedw=10 and overflow set, concurrent write ignored
    wrreq = 1'b1;
    for (int k = 0; k < 32; k++) begin
      din = 16'(16'h0300 + k);
      step();
    end
    din = 16'hBEEF;
    step();
    wrreq = 1'b0;
    rdreq = 1'b1;
    for (int k = 0; k < 22; k++) step();
    rdreq = 1'b0;
    chk("t5_usedw10", 32'(sa_usedw), 10);
    chk("t5_ovf1",    32'(sa_ovf), 1);
    flush = 1'b1; wrreq = 1'b1; din = 16'h5555;
    step();
    flush = 1'b0; wrreq = 1'b0;
    chk("t5_usedw0", 32'(sa_usedw), 0);
    chk("t5_empty",  32'(sa_empty), 1);
    chk("t5_ovf0",   32'(sa_ovf), 0);
    chk("t5_unf0",   32'(nm_unf), 0);
    chk("t5_nm_keep", 32'(nm_q), 32'h0315);
    step();
    chk("t5_still_empty", 32'(nm_empty), 1);

    // 6: reset mid-burst at usedw=17
    wrreq = 1'b1;
    for (int k = 0; k < 17; k++) begin
      din = 16'(16'h0400 + k);
      step();
    end
    chk("t6_usedw17", 32'(sa_usedw), 17);
    srst = 1'b1; rdreq = 1'b1;
    step();
    srst = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    chk("t6_usedw", 32'(sa_usedw), 0);
    chk("t6_empty", 32'(sa_empty), 1);
    chk("t6_full",  32'(sa_full), 0);
    chk("t6_ae",    32'(sa_ae), 1);
    chk("t6_af",    32'(sa_af), 0);
    chk("t6_ovf",   32'(sa_ovf), 0);
    chk("t6_unf",   32'(sa_unf), 0);
    chk("t6_q_sa",  32'(sa_q), 0);
    chk("t6_q_nm",  32'(nm_q), 0);
    wrreq = 1'b1; din = 16'h1234;
    step();
    wrreq = 1'b0;
    chk("t6_sa_q", 32'(sa_q), 32'h1234);
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk("t6_nm_q",  32'(nm_q), 32'h1234);
    chk("t6_empty2", 32'(nm_empty), 1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
